// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: prioritised thermometer stall code, multi-cycle EX tracking, branch flush.
// Optional load-use detection in decode is enabled by defining LOAD_USE_DET_EN.
module pipe_stall_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_wait,
    input  logic        id_hazard,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_start,
    input  logic [4:0]  ex_cycles,
    input  logic        mem_wait,
    input  logic        branch_taken,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        ex_busy,
    output logic [31:0] stall_count
);

    localparam int unsigned STG_W = 6;
    localparam int unsigned CYC_W = 5;
    localparam int unsigned CNT_W = 32;

    localparam logic [STG_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STG_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STG_W-1:0] STALL_DEC  = 6'b000111;
    localparam logic [STG_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STG_W-1:0] STALL_NONE = 6'b000000;

    typedef enum logic {
        RUN     = 1'b0,
        EX_BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [CYC_W-1:0]   cyc_cnt_nxt;
    logic               ex_busy_nxt;
    logic               dec_hazard;
    logic               ex_hold;
    logic [CNT_W-1:0]   stall_cnt_q;

`ifdef LOAD_USE_DET_EN
    // Load in EX whose destination feeds a source of the instruction in decode.
    logic load_use;
    assign load_use   = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign dec_hazard = id_hazard | load_use;
`else
    logic unused_load_use;
    assign unused_load_use = ^{ex_mem_read, ex_rd, id_rs1, id_rs2};
    assign dec_hazard      = id_hazard;
`endif

    // EX cannot advance while memory waits or a multi-cycle op is in flight.
    assign ex_hold = mem_wait | ex_busy;

    // A redirect leaving EX kills the younger decode hazard, so flush masks it.
    always_comb begin
        flush = rst_n & branch_taken & ~ex_hold;
        stall = STALL_NONE;
        if (rst_n) begin
            if (mem_wait)                 stall = STALL_MEM;
            else if (ex_busy)             stall = STALL_EX;
            else if (dec_hazard & ~flush) stall = STALL_DEC;
            else if (if_wait)             stall = STALL_IF;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            cyc_cnt <= '0;
            ex_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_cnt_nxt;
            ex_busy <= ex_busy_nxt;
        end
    end

    // FSM next state; counter holds remaining busy cycles including the current one
    always_comb begin
        state_nxt   = state;
        cyc_cnt_nxt = cyc_cnt;
        case (state)
            RUN: begin
                if (ex_start && (ex_cycles >= CYC_W'(2))) begin
                    cyc_cnt_nxt = ex_cycles - CYC_W'(1);
                    state_nxt   = EX_BUSY;
                end
            end
            EX_BUSY: begin
                cyc_cnt_nxt = (cyc_cnt == '0) ? '0 : cyc_cnt - CYC_W'(1);
                if (cyc_cnt <= CYC_W'(1)) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt   = RUN;
                cyc_cnt_nxt = '0;
            end
        endcase
        ex_busy_nxt = (state_nxt == EX_BUSY);
    end

    // Saturating count of cycles where the PC is held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall[0] && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt_q;

endmodule
